// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
// Imported by the arbiter and the top-level sequencer.
package mem_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_IO_WAIT,
      S_DONE
   } state_e;

   typedef enum logic {
      REQ_IF  = 1'b0,
      REQ_MEM = 1'b1
   } req_e;

   localparam logic [2:0] LEN_BYTE = 3'd1;
   localparam logic [2:0] LEN_HALF = 3'd2;
   localparam logic [2:0] LEN_WORD = 3'd4;

   localparam int         IO_SEL_HI_DEF  = 17;
   localparam logic [1:0] IO_SEL_VAL_DEF = 2'b11;

   // Anything other than a byte or half transfer runs as a word.
   function automatic logic [2:0] len_norm(
      input logic [2:0] len
   );
      if (len == LEN_BYTE || len == LEN_HALF)
         return len;
      return LEN_WORD;
   endfunction

endpackage

// File: rtl/mem_ctrl_arb.sv
// Request arbiter: MEM beats IF, fields latched on take_i.
// Ports: MEM/IF request fields in; pick_* describe the winner now, *_o hold the latched request.
module mem_ctrl_arb
   import mem_ctrl_pkg::*;
#(
   parameter int         ADDR_W     = 32,
   parameter int         IO_SEL_HI  = IO_SEL_HI_DEF,
   parameter logic [1:0] IO_SEL_VAL = IO_SEL_VAL_DEF
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              take_i,
   input  logic              mem_get_i,
   input  logic              mem_wr_i,
   input  logic [ADDR_W-1:0] mem_address_i,
   input  logic [31:0]       mem_data_i,
   input  logic [2:0]        mem_len_i,
   input  logic              if_get_i,
   input  logic [ADDR_W-1:0] if_address_i,
   output logic              any_o,
   output logic              pick_wr_o,
   output logic              pick_io_o,
   output req_e              req_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [3:0][7:0]   data_o,
   output logic [2:0]        len_o
);

   logic              sel_mem;
   logic [ADDR_W-1:0] pick_addr;

   req_e              req_q, req_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0][7:0]   data_q, data_d;
   logic [2:0]        len_q, len_d;

   always_comb begin
      sel_mem   = mem_get_i;
      pick_addr = sel_mem ? mem_address_i
                          : if_address_i;
      any_o     = mem_get_i | if_get_i;
      pick_wr_o = sel_mem & mem_wr_i;
      pick_io_o = pick_addr[IO_SEL_HI -: 2]
                  == IO_SEL_VAL;
   end

   always_comb begin
      req_d  = req_q;
      addr_d = addr_q;
      data_d = data_q;
      len_d  = len_q;
      if (take_i) begin
         req_d  = sel_mem ? REQ_MEM : REQ_IF;
         addr_d = pick_addr;
         data_d = sel_mem ? mem_data_i : '0;
         len_d  = sel_mem ? len_norm(mem_len_i)
                          : LEN_WORD;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         req_q  <= REQ_IF;
         addr_q <= '0;
         data_q <= '0;
         len_q  <= '0;
      end else begin
         req_q  <= req_d;
         addr_q <= addr_d;
         data_q <= data_d;
         len_q  <= len_d;
      end
   end

   assign req_o  = req_q;
   assign addr_o = addr_q;
   assign data_o = data_q;
   assign len_o  = len_q;

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: serialises MEM/IF requests onto an 8-bit RAM/IO bus.
// Ports: clk/rst/rdy, MEM and IF request/done pairs, ram_* byte bus, io_buffer_full.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int         ADDR_W     = 32,
   parameter int         IO_SEL_HI  = IO_SEL_HI_DEF,
   parameter logic [1:0] IO_SEL_VAL = IO_SEL_VAL_DEF
) (
   input  logic              clk_in,
   input  logic              rst_in,
   input  logic              rdy_in,
   input  logic              mem_get,
   input  logic              mem_wr,
   input  logic [ADDR_W-1:0] mem_address,
   input  logic [31:0]       mem_data,
   input  logic [2:0]        mem_len,
   output logic              mem_done,
   output logic [31:0]       mem_out,
   input  logic              if_get,
   input  logic [ADDR_W-1:0] if_address,
   output logic              if_done,
   output logic [31:0]       if_out,
   input  logic [7:0]        ram_din,
   output logic [7:0]        ram_dout,
   output logic [ADDR_W-1:0] ram_a,
   output logic              ram_wr,
   input  logic              io_buffer_full
);

   state_e            state_q;
   logic [2:0]        k_q;
   logic              cap_q;
   logic [3:0][7:0]   buf_q;

   logic              any;
   logic              pick_wr;
   logic              pick_io;
   logic              take;
   req_e              req;
   logic [ADDR_W-1:0] addr;
   logic [3:0][7:0]   data;
   logic [2:0]        len;

   assign take = (state_q == S_IDLE)
                 && rdy_in && any;

   mem_ctrl_arb #(
      .ADDR_W     (ADDR_W),
      .IO_SEL_HI  (IO_SEL_HI),
      .IO_SEL_VAL (IO_SEL_VAL)
   ) u_arb (
      .clk_i         (clk_in),
      .rst_ni        (rst_in),
      .take_i        (take),
      .mem_get_i     (mem_get),
      .mem_wr_i      (mem_wr),
      .mem_address_i (mem_address),
      .mem_data_i    (mem_data),
      .mem_len_i     (mem_len),
      .if_get_i      (if_get),
      .if_address_i  (if_address),
      .any_o         (any),
      .pick_wr_o     (pick_wr),
      .pick_io_o     (pick_io),
      .req_o         (req),
      .addr_o        (addr),
      .data_o        (data),
      .len_o         (len)
   );

   // k_q: index of the next byte to put on the bus.
   // cap_q: ram_din this cycle carries byte k_q-1.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q <= S_IDLE;
         k_q     <= '0;
         cap_q   <= 1'b0;
         buf_q   <= '0;
      end else if (rdy_in) begin
         unique case (state_q)
            S_IDLE: begin
               if (any) begin
                  k_q   <= '0;
                  cap_q <= 1'b0;
                  buf_q <= '0;
                  if (!pick_wr)
                     state_q <= S_READ;
                  else if (pick_io && io_buffer_full)
                     state_q <= S_IO_WAIT;
                  else
                     state_q <= S_WRITE;
               end
            end
            S_IO_WAIT: begin
               if (!io_buffer_full)
                  state_q <= S_WRITE;
            end
            S_WRITE: begin
               k_q <= k_q + 3'd1;
               if (k_q == len - 3'd1)
                  state_q <= S_DONE;
            end
            S_READ: begin
               if (cap_q) begin
                  buf_q[2'(k_q - 3'd1)] <= ram_din;
                  if (k_q == len)
                     state_q <= S_DONE;
               end
               cap_q <= (k_q != len);
               if (k_q != len)
                  k_q <= k_q + 3'd1;
            end
            S_DONE: state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end else if (state_q == S_READ && cap_q) begin
         // Returning byte is lost; step back so it is re-fetched.
         k_q   <= k_q - 3'd1;
         cap_q <= 1'b0;
      end
   end

   always_comb begin
      ram_wr   = 1'b0;
      ram_a    = '0;
      ram_dout = '0;
      mem_done = 1'b0;
      mem_out  = '0;
      if_done  = 1'b0;
      if_out   = '0;
      unique case (1'b1)
         state_q == S_WRITE: begin
            ram_a    = addr + ADDR_W'(k_q);
            ram_dout = data[k_q[1:0]];
            ram_wr   = rdy_in;
         end
         state_q == S_READ: begin
            if (k_q != len)
               ram_a = addr + ADDR_W'(k_q);
         end
         state_q == S_DONE: begin
            if (rdy_in && req == REQ_MEM) begin
               mem_done = 1'b1;
               mem_out  = buf_q;
            end
            if (rdy_in && req == REQ_IF) begin
               if_done = 1'b1;
               if_out  = buf_q;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed and randomised checks of mem_ctrl against a byte-memory model.
// Drives at negedge, samples at negedge before driving.
module tb_mem_ctrl;

   logic        clk = 1'b0;
   logic        rst_in = 1'b0;
   logic        rdy_in = 1'b1;
   logic        mem_get = 1'b0;
   logic        mem_wr = 1'b0;
   logic [31:0] mem_address = '0;
   logic [31:0] mem_data = '0;
   logic [2:0]  mem_len = 3'd4;
   logic        mem_done;
   logic [31:0] mem_out;
   logic        if_get = 1'b0;
   logic [31:0] if_address = '0;
   logic        if_done;
   logic [31:0] if_out;
   logic [7:0]  ram_din = '0;
   logic [7:0]  ram_dout;
   logic [31:0] ram_a;
   logic        ram_wr;
   logic        io_buffer_full = 1'b0;

   int n_pass = 0;
   int n_tot  = 0;

   logic [7:0]  pre  [logic [31:0]];
   logic [7:0]  ram  [logic [31:0]];
   logic [7:0]  refm [logic [31:0]];
   logic [39:0] wq [$];

   always #5 clk = ~clk;

   mem_ctrl dut (
      .clk_in         (clk),
      .rst_in         (rst_in),
      .rdy_in         (rdy_in),
      .mem_get        (mem_get),
      .mem_wr         (mem_wr),
      .mem_address    (mem_address),
      .mem_data       (mem_data),
      .mem_len        (mem_len),
      .mem_done       (mem_done),
      .mem_out        (mem_out),
      .if_get         (if_get),
      .if_address     (if_address),
      .if_done        (if_done),
      .if_out         (if_out),
      .ram_din        (ram_din),
      .ram_dout       (ram_dout),
      .ram_a          (ram_a),
      .ram_wr         (ram_wr),
      .io_buffer_full (io_buffer_full)
   );

   function automatic logic [7:0] init_b(
      input logic [31:0] a
   );
      if (pre.exists(a)) return pre[a];
      return a[7:0] ^ a[15:8] ^ 8'h5A;
   endfunction

   function automatic logic [7:0] ram_rd(
      input logic [31:0] a
   );
      if (ram.exists(a)) return ram[a];
      return init_b(a);
   endfunction

   function automatic logic [7:0] ref_rd(
      input logic [31:0] a
   );
      if (refm.exists(a)) return refm[a];
      return init_b(a);
   endfunction

   // RAM/IO bus: one-cycle read latency.
   always @(posedge clk) begin
      ram_din <= ram_rd(ram_a);
      if (ram_wr) ram[ram_a] = ram_dout;
   end

   always @(negedge clk)
      if (ram_wr) wq.push_back({ram_a, ram_dout});

   task automatic check(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      n_tot++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %08h want %08h",
                  tag, obs, exp);
   endtask

   task automatic check_idle_outs(input string tag);
      check({tag, " mem_done"}, 32'(mem_done), 0);
      check({tag, " if_done"},  32'(if_done), 0);
      check({tag, " mem_out"},  mem_out, 0);
      check({tag, " if_out"},   if_out, 0);
      check({tag, " ram_wr"},   32'(ram_wr), 0);
      check({tag, " ram_a"},    ram_a, 0);
      check({tag, " ram_dout"}, 32'(ram_dout), 0);
   endtask

   function automatic logic [31:0] ref_word(
      input logic [31:0] a,
      input int          n
   );
      logic [31:0] w = '0;
      for (int i = 0; i < n; i++)
         w[8*i +: 8] = ref_rd(a + 32'(i));
      return w;
   endfunction

   task automatic run_op(
      input string       tag,
      input bit          is_if,
      input bit          wr,
      input logic [31:0] a,
      input logic [31:0] d,
      input logic [2:0]  len,
      input bit          pause
   );
      int          n, base, lat;
      bit          seen, other, st;
      logic [31:0] exp, got;
      st   = wr && !is_if;
      n    = (is_if || !(len == 3'd1 || len == 3'd2))
             ? 4 : int'(len);
      base = st ? n + 1 : n + 2;
      exp  = st ? 32'h0 : ref_word(a, n);
      @(negedge clk);
      wq.delete();
      if (is_if) begin
         if_get     = 1'b1;
         if_address = a;
      end else begin
         mem_get     = 1'b1;
         mem_wr      = wr;
         mem_address = a;
         mem_data    = d;
         mem_len     = len;
      end
      seen = 0; other = 0; lat = 0; got = '0;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         if (is_if ? mem_done : if_done) other = 1;
         if (is_if ? if_done : mem_done) begin
            seen = 1;
            lat  = c;
            got  = is_if ? if_out : mem_out;
            break;
         end
         if (pause && c == 1) rdy_in = 1'b0;
         if (pause && c == 4) rdy_in = 1'b1;
      end
      rdy_in  = 1'b1;
      mem_get = 1'b0;
      if_get  = 1'b0;
      check({tag, " done"}, 32'(seen), 1);
      if (pause)
         check({tag, " lat"},
               32'(lat >= base + 3 && lat <= base + 4), 1);
      else
         check({tag, " lat"}, lat, base);
      check({tag, " data"}, got, exp);
      check({tag, " other done"}, 32'(other), 0);
      if (st) begin
         check({tag, " nwr"}, wq.size(), n);
         for (int i = 0; i < n && i < wq.size(); i++) begin
            check({tag, " wa"}, wq[i][39:8], a + 32'(i));
            check({tag, " wd"}, 32'(wq[i][7:0]),
                  32'(d[8*i +: 8]));
         end
         for (int i = 0; i < n; i++)
            refm[a + 32'(i)] = d[8*i +: 8];
      end else begin
         check({tag, " nwr"}, wq.size(), 0);
      end
   endtask

   initial begin
      bit           bad, seen;
      int           c;
      logic [31:0]  a, d;
      logic [2:0]   len;
      logic [2:0]   lens [5] = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd0};

      pre[32'h1000] = 8'h11; pre[32'h1001] = 8'h22;
      pre[32'h1002] = 8'h33; pre[32'h1003] = 8'h44;
      pre[32'h2003] = 8'h80;
      pre[32'h2000] = 8'hFE; pre[32'h2001] = 8'hFF;

      repeat (3) @(negedge clk);
      check_idle_outs("reset");
      rst_in = 1'b1;

      run_op("LW",  0, 0, 32'h1000, 0, 3'd4, 0);
      check("LW value", mem_out | ref_word(32'h1000, 4),
            32'h44332211);
      run_op("LB",  0, 0, 32'h2003, 0, 3'd1, 0);
      run_op("LHU", 0, 0, 32'h2000, 0, 3'd2, 0);
      run_op("SH",  0, 1, 32'h3000, 32'hDEADBEEF, 3'd2, 0);
      run_op("LW3000", 0, 0, 32'h3000, 0, 3'd4, 0);

      // MEM and IF together: MEM first, IF right after.
      @(negedge clk);
      mem_get = 1'b1; mem_wr = 1'b0;
      mem_address = 32'h1000; mem_len = 3'd4;
      if_get = 1'b1; if_address = 32'h2000;
      bad = 0; seen = 0; c = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (if_done) bad = 1;
         if (mem_done) begin seen = 1; c = i; break; end
      end
      check("sim mem done", 32'(seen), 1);
      check("sim mem lat", c, 6);
      check("sim mem data", mem_out, 32'h44332211);
      check("sim early if", 32'(bad), 0);
      mem_get = 1'b0;
      seen = 0; c = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (if_done) begin seen = 1; c = i; break; end
      end
      check("sim if done", 32'(seen), 1);
      check("sim if lat", c, 7);
      check("sim if data", if_out, ref_word(32'h2000, 4));
      if_get = 1'b0;

      // IO store held off by a full output buffer.
      @(negedge clk);
      wq.delete();
      io_buffer_full = 1'b1;
      mem_get = 1'b1; mem_wr = 1'b1;
      mem_address = 32'h30000;
      mem_data = 32'h123456A5; mem_len = 3'd1;
      bad = 0;
      for (int i = 1; i <= 5; i++) begin
         @(negedge clk);
         if (ram_wr || mem_done) bad = 1;
      end
      check("io wait quiet", 32'(bad), 0);
      io_buffer_full = 1'b0;
      @(negedge clk);
      check("io wr", 32'(ram_wr), 1);
      check("io a", ram_a, 32'h30000);
      check("io d", 32'(ram_dout), 32'hA5);
      @(negedge clk);
      check("io done", 32'(mem_done), 1);
      check("io out", mem_out, 0);
      mem_get = 1'b0;
      check("io nwr", wq.size(), 1);
      refm[32'h30000] = 8'hA5;

      run_op("LW pause", 0, 0, 32'h1000, 0, 3'd4, 1);
      run_op("SW pause", 0, 1, 32'h1040,
             32'hCAFEF00D, 3'd4, 1);

      // Reset in the middle of a load.
      @(negedge clk);
      mem_get = 1'b1; mem_wr = 1'b0;
      mem_address = 32'h1000; mem_len = 3'd4;
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (mem_done) bad = 1;
      end
      rst_in = 1'b0;
      mem_get = 1'b0;
      @(negedge clk);
      check_idle_outs("midrst");
      rst_in = 1'b1;
      repeat (8) begin
         @(negedge clk);
         if (mem_done || if_done) bad = 1;
      end
      check("midrst no done", 32'(bad), 0);
      run_op("post rst", 0, 0, 32'h1000, 0, 3'd4, 0);
      run_op("wrap IF", 1, 0, 32'hFFFFFFFE, 0, 3'd4, 0);

      for (int t = 0; t < 40; t++) begin
         int k;
         k = $urandom_range(0, 3);
         if ($urandom_range(0, 7) == 0)
            a = 32'hFFFFFFFC + $urandom_range(0, 3);
         else
            a = 32'h1000 + $urandom_range(0, 255);
         d   = $urandom;
         len = lens[$urandom_range(0, 4)];
         run_op($sformatf("rnd%0d", t), k == 0, k == 1,
                a, d, len, $urandom_range(0, 4) == 0);
      end

      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

endmodule
